// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit of the 5-stage core.
// Issues D-cache requests, aligns load data and holds the pipeline while busy.
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_out_in,
    input  logic [XLEN-1:0] st_data,
    input  logic            ext_stall,
    output logic            dc_req,
    output logic            dc_we,
    output logic [XLEN-1:0] dc_addr,
    output logic [3:0]      dc_wstrb,
    output logic [XLEN-1:0] dc_wdata,
    input  logic            dc_gnt,
    input  logic            dc_done,
    input  logic [XLEN-1:0] dc_rdata,
    output logic [XLEN-1:0] alu_out_out,
    output logic [XLEN-1:0] ld_data_out,
    output logic            cacheStall,
    output logic            misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_ld_q;
    logic            r_is_load;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;

    logic            w_mem_op;
    logic            w_misal;
    logic            w_issue;
    logic [1:0]      w_off;
    logic [3:0]      w_strb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_ld_ext;

    assign w_mem_op = mem_read | mem_write;
    assign w_off    = alu_out_in[1:0];
    assign w_issue  = (r_state == S_IDLE) & w_mem_op & ~w_misal;

    // Size decode: alignment check, byte enables and lane replication.
    always_comb begin
        w_misal = 1'b0;
        w_strb  = 4'b1111;
        w_wdata = st_data;
        case (funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << w_off;
                w_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                w_misal = w_off[0];
                w_strb  = 4'b0011 << w_off;
                w_wdata = {2{st_data[15:0]}};
            end
            default: begin
                w_misal = |w_off;
                w_strb  = 4'b1111;
                w_wdata = st_data;
            end
        endcase
    end

    // Load extraction uses the size/offset latched at grant time.
    always_comb begin
        w_shift  = dc_rdata >> {r_off, 3'b000};
        w_ld_ext = dc_rdata;
        case (r_f3)
            3'b000: w_ld_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100: w_ld_ext = {24'd0, w_shift[7:0]};
            3'b001: w_ld_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101: w_ld_ext = {16'd0, w_shift[15:0]};
            default: w_ld_ext = dc_rdata;
        endcase
    end

    // Transaction FSM: request in IDLE, wait for completion, present result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ld_q    <= '0;
            r_is_load <= 1'b0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue && dc_gnt) begin
                        r_state   <= S_WAIT;
                        r_is_load <= mem_read;
                        r_f3      <= funct3;
                        r_off     <= w_off;
                    end
                end
                S_WAIT: begin
                    if (dc_done) begin
                        r_ld_q  <= r_is_load ? w_ld_ext : '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ext_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dc_req      = w_issue;
    assign dc_we       = w_issue & mem_write;
    assign dc_addr     = {alu_out_in[XLEN-1:2], 2'b00};
    assign dc_wstrb    = (w_issue & mem_write) ? w_strb : 4'b0000;
    assign dc_wdata    = w_wdata;
    assign alu_out_out = alu_out_in;
    assign ld_data_out = (r_state == S_DONE) ? r_ld_q : '0;
    assign cacheStall  = w_issue | (r_state == S_WAIT);
    assign misalign    = (r_state == S_IDLE) & w_mem_op & w_misal;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized and directed checks of mem_stage_lsu
// against a behavioural cache responder and load/store reference model.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_out_in;
    logic [31:0] st_data;
    logic        ext_stall;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_gnt;
    logic        dc_done;
    logic [31:0] dc_rdata;
    logic [31:0] alu_out_out;
    logic [31:0] ld_data_out;
    logic        cacheStall;
    logic        misalign;

    int n_chk;
    int n_fail;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .alu_out_in  (alu_out_in),
        .st_data     (st_data),
        .ext_stall   (ext_stall),
        .dc_req      (dc_req),
        .dc_we       (dc_we),
        .dc_addr     (dc_addr),
        .dc_wstrb    (dc_wstrb),
        .dc_wdata    (dc_wdata),
        .dc_gnt      (dc_gnt),
        .dc_done     (dc_done),
        .dc_rdata    (dc_rdata),
        .alu_out_out (alu_out_out),
        .ld_data_out (ld_data_out),
        .cacheStall  (cacheStall),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        longint w;
        longint v;
        w = longint'(rd) >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: begin v = w & 'hFF;   if (v >= 128)   v = v - 256;   end
            3'd4: begin v = w & 'hFF;                                   end
            3'd1: begin v = w & 'hFFFF; if (v >= 32768) v = v - 65536; end
            3'd5: begin v = w & 'hFFFF;                                 end
            default: v = longint'(rd);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return 32'(sd[7:0] * 32'h01010101);
        if (f3 == 3'd1) return 32'(sd[15:0] * 32'h00010001);
        return sd;
    endfunction

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        alu_out_in = 32'd0;
        st_data    = 32'd0;
        ext_stall  = 1'b0;
        dc_gnt     = 1'b0;
        dc_done    = 1'b0;
        dc_rdata   = 32'd0;
    endtask

    // One instruction through MEM; the bench acts as the cache and
    // releases ext_stall after eh cycles in the result cycle.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int gw, input int dw,
                          input int eh, input bit dup);
        bit          mis;
        int          t;
        int          stall_seen;
        logic [31:0] exp_ld;
        mem_read   = ld;
        mem_write  = st;
        funct3     = f3;
        alu_out_in = a;
        st_data    = sd;
        dc_rdata   = rd;
        dc_gnt     = 1'b0;
        dc_done    = 1'b0;
        ext_stall  = 1'b0;
        mis = (ld || st) && ref_misaligned(f3, a);
        if (!(ld || st) || mis) begin
            @(negedge clk);
            n_chk++;
            if (cacheStall !== 1'b0 || dc_req !== 1'b0 || ld_data_out !== 32'd0 ||
                misalign !== mis || alu_out_out !== a) begin
                n_fail++;
                $display("FAIL nomem_or_misalign a=%h: stall=%b req=%b ld=%h mis=%b alu=%h want 0 0 0 %b %h",
                         a, cacheStall, dc_req, ld_data_out, misalign, alu_out_out, mis, a);
            end
            @(posedge clk);
            #1;
            return;
        end
        exp_ld = ld ? ref_load(f3, a, rd) : 32'd0;
        t = gw + 2 + dw;
        stall_seen = 0;
        for (int c = 0; c <= t + eh; c++) begin
            dc_gnt    = (c == gw);
            dc_done   = (c == gw + 1 + dw) || (dup && c == gw);
            ext_stall = (c >= t) && (c < t + eh);
            @(negedge clk);
            if (cacheStall === 1'b1) stall_seen++;
            n_chk++;
            if (cacheStall !== (c < t) || dc_req !== (c <= gw) || misalign !== 1'b0) begin
                n_fail++;
                $display("FAIL handshake cyc=%0d: stall=%b req=%b mis=%b want %b %b 0",
                         c, cacheStall, dc_req, misalign, (c < t), (c <= gw));
            end
            if (c == 0) begin
                n_chk++;
                if (dc_addr !== {a[31:2], 2'b00} || dc_we !== st || alu_out_out !== a) begin
                    n_fail++;
                    $display("FAIL request a=%h: addr=%h we=%b alu=%h want %h %b %h",
                             a, dc_addr, dc_we, alu_out_out, {a[31:2], 2'b00}, st, a);
                end
                if (st) begin
                    n_chk++;
                    if (dc_wstrb !== ref_strb(f3, a) || dc_wdata !== ref_wdata(f3, sd)) begin
                        n_fail++;
                        $display("FAIL store f3=%0d a=%h: wstrb=%b wdata=%h want %b %h",
                                 f3, a, dc_wstrb, dc_wdata, ref_strb(f3, a), ref_wdata(f3, sd));
                    end
                end
            end
            if (c >= t) begin
                n_chk++;
                if (ld_data_out !== exp_ld) begin
                    n_fail++;
                    $display("FAIL ld_data f3=%0d a=%h cyc=%0d: got %h want %h",
                             f3, a, c, ld_data_out, exp_ld);
                end
            end
            @(posedge clk);
            #1;
        end
        dc_gnt    = 1'b0;
        dc_done   = 1'b0;
        ext_stall = 1'b0;
        n_chk++;
        if (stall_seen != 2 + gw + dw) begin
            n_fail++;
            $display("FAIL stall_len: got %0d want %0d", stall_seen, 2 + gw + dw);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (dc_req !== 1'b0 || cacheStall !== 1'b0 || ld_data_out !== 32'd0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: req=%b stall=%b ld=%h mis=%b want 0 0 0 0",
                     dc_req, cacheStall, ld_data_out, misalign);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_op(1, 0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 0, 0);
        run_op(1, 0, 3'd0, 32'h103, 32'd0, 32'h80FF7F01, 0, 0, 0, 0);
        run_op(1, 0, 3'd4, 32'h103, 32'd0, 32'h80FF7F01, 0, 0, 0, 0);
        run_op(1, 0, 3'd5, 32'h102, 32'd0, 32'h80FF7F01, 0, 0, 0, 0);
        run_op(1, 0, 3'd1, 32'h102, 32'd0, 32'h80FF7F01, 0, 0, 0, 0);
        run_op(0, 1, 3'd1, 32'h106, 32'h1234ABCD, 32'd0, 0, 0, 0, 0);
        run_op(0, 1, 3'd0, 32'h109, 32'h000000A5, 32'd0, 0, 0, 0, 0);
        run_op(1, 0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 0, 0, 0);
        run_op(0, 1, 3'd1, 32'h203, 32'h55, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic test_delay_and_hold();
        run_op(1, 0, 3'd2, 32'h300, 32'd0, 32'hCAFEF00D, 3, 1, 2, 1);
    endtask

    task automatic test_reset_in_wait();
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'd2;
        alu_out_in = 32'h400;
        dc_rdata   = 32'h12345678;
        dc_gnt     = 1'b1;
        @(posedge clk);
        #1;
        dc_gnt = 1'b0;
        rst    = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cacheStall !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_stall: got %b want 1", cacheStall);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        dc_done = 1'b1;
        @(negedge clk);
        n_chk++;
        if (dc_req !== 1'b0 || cacheStall !== 1'b0 || ld_data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wait: req=%b stall=%b ld=%h want 0 0 0",
                     dc_req, cacheStall, ld_data_out);
        end
        @(posedge clk);
        #1;
        dc_done = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cacheStall !== 1'b0 || ld_data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL late_done: stall=%b ld=%h want 0 0", cacheStall, ld_data_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_f3 = '{3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
            f3 = (kind == 1) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            run_op(kind == 0, kind == 1, f3, a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_directed();
        test_delay_and_hold();
        test_reset_in_wait();
        test_back_to_back();
        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
